overlap_add: RTL and testbench



---
 rtl/overlap_add_pkg.sv | 37 +++
 rtl/overlap_add_tail_buf.sv | 40 ++++
 rtl/overlap_add.sv | 138 +++++++++++++
 tb/tb_overlap_add.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/overlap_add_pkg.sv
// Shared types and helpers for the overlap-add reconstruction block:
// FSM state encoding, index sizing, framing legality and the saturating adder.
package overlap_add_pkg;

  localparam int DATA_W_DEF = 16;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  // Index width that never collapses to zero bits (1- and 0-entry arrays still get a 1-bit index).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // HOP >= OV guarantees every tail slot is read before it is rewritten in place.
  function automatic bit hop_legal(input int frameLen, input int hop);
    return (hop >= 1) && (hop <= frameLen) && (2 * hop >= frameLen);
  endfunction

  // Operands arrive sign-extended; the result is clamped to a w-bit signed range.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int w);
    longint sum;
    longint hi;
    longint lo;
    sum = longint'(a) + longint'(b);
    hi  = (longint'(1) <<< (w - 1)) - 1;
    lo  = -(longint'(1) <<< (w - 1));
    if (sum > hi) return 32'(hi);
    if (sum < lo) return 32'(lo);
    return 32'(sum);
  endfunction

endpackage

// File: rtl/overlap_add_tail_buf.sv
// Retained tail of the previous frame: OV samples with one combinational read port,
// one write port and a per-entry clear used while draining.
module overlap_add_tail_buf
  import overlap_add_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int OV     = 4,
  parameter int TW     = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [TW-1:0]            rd_idx_i,
  output logic signed [DATA_W-1:0] rd_data_o,
  input  logic                     wr_en_i,
  input  logic [TW-1:0]            wr_idx_i,
  input  logic signed [DATA_W-1:0] wr_data_i,
  input  logic                     clr_en_i,
  input  logic [TW-1:0]            clr_idx_i
);

  if (OV > 0) begin : g_buf
    logic signed [DATA_W-1:0] mem_q [OV];

    always_ff @(posedge clk) begin
      if (!reset) begin
        for (int i = 0; i < OV; i++) mem_q[i] <= '0;
      end else begin
        if (wr_en_i)  mem_q[wr_idx_i]  <= wr_data_i;
        if (clr_en_i) mem_q[clr_idx_i] <= '0;
      end
    end

    assign rd_data_o = mem_q[rd_idx_i];
  end else begin : g_none
    logic unusedInputs;
    assign unusedInputs = ^{clk, reset, rd_idx_i, wr_en_i, wr_idx_i, wr_data_i, clr_en_i, clr_idx_i};
    assign rd_data_o    = '0;
  end

endmodule

// File: rtl/overlap_add.sv
// Overlap-add synthesis: folds each frame's head onto the stored tail of the previous
// frame, emits HOP samples per frame through an output register, and drains the tail on flush.
module overlap_add
  import overlap_add_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int FRAME_LEN = 8,
  parameter int HOP       = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] in_pcmSample,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_flush,
  output logic signed [DATA_W-1:0] out_pcmSample,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     flush_done
);

  localparam int OV = FRAME_LEN - HOP;
  localparam int IW = idx_w(FRAME_LEN);
  localparam int TW = idx_w(OV);
  localparam int LW = IW + 1;
  localparam logic [IW:0] OV_C        = LW'(OV);
  localparam logic [IW:0] HOP_C       = LW'(HOP);
  localparam logic [IW:0] LAST_C      = LW'(FRAME_LEN - 1);
  localparam logic [IW:0] TAIL_LAST_C = LW'((OV > 0) ? OV - 1 : 0);

  if (!hop_legal(FRAME_LEN, HOP)) begin : g_bad_hop
    $error("overlap_add: HOP must satisfy FRAME_LEN/2 <= HOP <= FRAME_LEN");
  end

  state_e                   state_q, state_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic signed [DATA_W-1:0] outData_q, outData_d;
  logic                     outValid_q, outValid_d;
  logic                     flushDone_q, flushDone_d;

  logic                     outFree, flushReq, accept;
  logic                     idxLast, inOverlap, inHop, tailLast;
  logic                     tailWr, tailClr;
  logic signed [DATA_W-1:0] tailRd;

  assign outFree   = !outValid_q || out_ready;
  assign flushReq  = in_flush && (idx_q == '0);
  assign in_ready  = reset && (state_q == RUN) && outFree && !flushReq;
  assign accept    = in_valid && in_ready;
  assign idxLast   = ({1'b0, idx_q} == LAST_C);
  assign inOverlap = ({1'b0, idx_q} < OV_C);
  assign inHop     = ({1'b0, idx_q} < HOP_C);
  assign tailLast  = ({1'b0, idx_q} == TAIL_LAST_C);

  // idx doubles as the drain pointer in FLUSH; it is 0 on entry and returns to 0 on exit.
  overlap_add_tail_buf #(
    .DATA_W (DATA_W),
    .OV     (OV),
    .TW     (TW)
  ) u_tail (
    .clk       (clk),
    .reset     (reset),
    .rd_idx_i  (TW'(idx_q)),
    .rd_data_o (tailRd),
    .wr_en_i   (tailWr),
    .wr_idx_i  (TW'(idx_q - IW'(HOP))),
    .wr_data_i (in_pcmSample),
    .clr_en_i  (tailClr),
    .clr_idx_i (TW'(idx_q))
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    outData_d   = outData_q;
    outValid_d  = outValid_q && !out_ready;
    flushDone_d = 1'b0;
    tailWr      = 1'b0;
    tailClr     = 1'b0;
    case (state_q)
      RUN: begin
        if (flushReq) begin
          state_d = FLUSH;
        end else if (accept) begin
          idx_d = idxLast ? '0 : idx_q + 1'b1;
          if (inOverlap) begin
            outData_d  = DATA_W'(sat_add(32'(tailRd), 32'(in_pcmSample), DATA_W));
            outValid_d = 1'b1;
          end else if (inHop) begin
            outData_d  = in_pcmSample;
            outValid_d = 1'b1;
          end else begin
            tailWr = 1'b1;
          end
        end
      end
      FLUSH: begin
        if (OV == 0) begin
          state_d     = RUN;
          flushDone_d = 1'b1;
        end else if (outFree) begin
          outData_d  = tailRd;
          outValid_d = 1'b1;
          tailClr    = 1'b1;
          if (tailLast) begin
            idx_d       = '0;
            state_d     = RUN;
            flushDone_d = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= RUN;
      idx_q       <= '0;
      outData_q   <= '0;
      outValid_q  <= 1'b0;
      flushDone_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      outData_q   <= outData_d;
      outValid_q  <= outValid_d;
      flushDone_q <= flushDone_d;
    end
  end

  assign out_pcmSample = outData_q;
  assign out_valid     = outValid_q;
  assign flush_done    = flushDone_q;

endmodule

// File: tb/tb_overlap_add.sv
// Directed bench for overlap_add: table-driven frames with hand-computed outputs,
// plus sequences for stall, early flush, mid-frame reset and the OV == 0 passthrough.
module tb_overlap_add;

  localparam int DW = 16;

  typedef struct {
    logic signed [DW-1:0] sample;
    bit                   expOut;
    logic signed [DW-1:0] expVal;
  } vec_t;

  typedef struct {
    logic signed [DW-1:0] data;
    bit                   fd;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset;
  logic signed [DW-1:0] inSample, outSample;
  logic                 inValid, inReady, inFlush, outValid, outReady, flushDone;
  logic signed [DW-1:0] pSample, pOut;
  logic                 pValid, pReady, pFlush, pOutValid, pOutReady, pFd;

  overlap_add #(.DATA_W(DW), .FRAME_LEN(8), .HOP(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_pcmSample  (inSample),
    .in_valid      (inValid),
    .in_ready      (inReady),
    .in_flush      (inFlush),
    .out_pcmSample (outSample),
    .out_valid     (outValid),
    .out_ready     (outReady),
    .flush_done    (flushDone)
  );

  overlap_add #(.DATA_W(DW), .FRAME_LEN(8), .HOP(8)) dutPass (
    .clk           (clk),
    .reset         (reset),
    .in_pcmSample  (pSample),
    .in_valid      (pValid),
    .in_ready      (pReady),
    .in_flush      (pFlush),
    .out_pcmSample (pOut),
    .out_valid     (pOutValid),
    .out_ready     (pOutReady),
    .flush_done    (pFd)
  );

  int                   compared = 0;
  int                   mismatched = 0;
  int                   acceptedCount = 0;
  bit                   lastAccepted, lastInReady, lastOutValid, lastFd;
  logic signed [DW-1:0] lastOutSample;
  obs_t                 got[$];
  logic signed [DW-1:0] expQ[$];
  bit                   expFd[$];
  vec_t                 vecs[$];
  logic signed [DW-1:0] passVals [8];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: actual %0h required %0h", name, actual, expected);
    end
  endtask

  // Drive at the negedge, observe 1 time unit later, then wait for the next negedge.
  task automatic applyStimulus(input bit v, input logic signed [DW-1:0] x, input bit fl, input bit rdy);
    inValid  = v;
    inSample = x;
    inFlush  = fl;
    outReady = rdy;
    #1;
    lastInReady   = inReady;
    lastAccepted  = inValid && inReady;
    lastOutValid  = outValid;
    lastOutSample = outSample;
    lastFd        = flushDone;
    if (lastAccepted) acceptedCount++;
    if (outValid && outReady) got.push_back('{outSample, flushDone});
    @(negedge clk);
  endtask

  task automatic clearCapture();
    got.delete();
    expQ.delete();
    expFd.delete();
    vecs.delete();
    acceptedCount = 0;
  endtask

  task automatic doReset(input int cycles);
    reset = 1'b0;
    repeat (cycles) applyStimulus(1'b0, '0, 1'b0, 1'b1);
    reset = 1'b1;
    clearCapture();
  endtask

  task automatic pushExp(input logic signed [DW-1:0] v, input bit fd);
    expQ.push_back(v);
    expFd.push_back(fd);
  endtask

  task automatic addVec(input logic signed [DW-1:0] x, input bit e, input logic signed [DW-1:0] ev);
    vecs.push_back('{x, e, ev});
  endtask

  task automatic sendSample(input logic signed [DW-1:0] x);
    int tries = 0;
    do begin
      applyStimulus(1'b1, x, 1'b0, 1'b1);
      tries++;
    end while (!lastAccepted && tries < 20);
    checkOutput("send accepted", 32'(lastAccepted), 32'd1);
  endtask

  task automatic runVectors();
    for (int i = 0; i < vecs.size(); i++) begin
      sendSample(vecs[i].sample);
      if (vecs[i].expOut) pushExp(vecs[i].expVal, 1'b0);
    end
    repeat (2) applyStimulus(1'b0, '0, 1'b0, 1'b1);
    vecs.delete();
  endtask

  // The requester drops in_flush (and in_valid) as soon as flush_done is visible.
  task automatic doFlush(input bit v, input logic signed [DW-1:0] x);
    bit done = 1'b0;
    for (int c = 0; c < 30 && !done; c++) begin
      applyStimulus(v && !flushDone, x, !flushDone, 1'b1);
      done = lastFd;
    end
    checkOutput("flush_done seen", 32'(done), 32'd1);
  endtask

  task automatic compareCapture(input string name);
    checkOutput({name, " count"}, got.size(), expQ.size());
    for (int i = 0; i < expQ.size() && i < got.size(); i++) begin
      checkOutput($sformatf("%s out[%0d]", name, i), 32'(got[i].data), 32'(expQ[i]));
      checkOutput($sformatf("%s fd[%0d]", name, i), 32'(got[i].fd), 32'(expFd[i]));
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset     = 1'b0;
    inValid   = 1'b0;
    inSample  = '0;
    inFlush   = 1'b0;
    outReady  = 1'b1;
    pValid    = 1'b0;
    pSample   = '0;
    pFlush    = 1'b0;
    pOutReady = 1'b1;

    // Reset state
    repeat (2) applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("reset out_valid", 32'(outValid), 32'd0);
    checkOutput("reset out_pcmSample", 32'(outSample), 32'd0);
    checkOutput("reset flush_done", 32'(flushDone), 32'd0);
    checkOutput("reset in_ready", 32'(lastInReady), 32'd0);
    checkOutput("reset pass out_valid", 32'(pOutValid), 32'd0);
    reset = 1'b1;
    clearCapture();

    // Two frames of ones, then flush
    for (int i = 0; i < 16; i++)
      addVec(16'sd1, (i % 8) < 4, (i < 8) ? 16'sd1 : 16'sd2);
    runVectors();
    for (int i = 0; i < 3; i++) pushExp(16'sd1, 1'b0);
    pushExp(16'sd1, 1'b1);
    doFlush(1'b0, '0);
    compareCapture("unity");

    // Saturation in both directions
    doReset(2);
    addVec(16'sd0, 1, 16'sd0);       addVec(16'sd0, 1, 16'sd0);
    addVec(16'sd0, 1, 16'sd0);       addVec(16'sd0, 1, 16'sd0);
    addVec(16'sh7000, 0, '0);        addVec(16'sh9000, 0, '0);
    addVec(16'sh7000, 0, '0);        addVec(16'sh9000, 0, '0);
    addVec(16'sh7000, 1, 16'sh7FFF); addVec(16'sh9000, 1, 16'sh8000);
    addVec(16'sh0001, 1, 16'sh7001); addVec(16'sh8000, 1, 16'sh8000);
    addVec(16'sh1234, 0, '0);        addVec(16'shFFFF, 0, '0);
    addVec(16'sh0000, 0, '0);        addVec(16'sh0000, 0, '0);
    runVectors();
    pushExp(16'sh1234, 0); pushExp(16'shFFFF, 0); pushExp(16'sh0000, 0); pushExp(16'sh0000, 1);
    doFlush(1'b0, '0);
    compareCapture("saturate");

    // Backpressure mid-frame
    doReset(2);
    for (int i = 0; i < 8; i++) addVec(DW'(i + 1), i < 4, DW'(i + 1));
    runVectors();
    sendSample(16'sd10);
    sendSample(16'sd11);
    pushExp(16'sd15, 0);
    pushExp(16'sd17, 0);
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1'b1, 16'sd12, 1'b0, 1'b0);
      checkOutput("stall in_ready", 32'(lastInReady), 32'd0);
      checkOutput("stall out_valid", 32'(lastOutValid), 32'd1);
      checkOutput("stall hold", 32'(lastOutSample), 32'd17);
    end
    addVec(16'sd12, 1, 16'sd19); addVec(16'sd13, 1, 16'sd21);
    addVec(16'sd14, 0, '0);      addVec(16'sd15, 0, '0);
    addVec(16'sd16, 0, '0);      addVec(16'sd17, 0, '0);
    runVectors();
    pushExp(16'sd14, 0); pushExp(16'sd15, 0); pushExp(16'sd16, 0); pushExp(16'sd17, 1);
    doFlush(1'b0, '0);
    compareCapture("stall");

    // Flush requested after 3 samples waits for the frame boundary
    doReset(2);
    sendSample(16'sd1);
    sendSample(16'sd2);
    sendSample(16'sd3);
    acceptedCount = 0;
    for (int c = 0; c < 10 && acceptedCount < 5; c++)
      applyStimulus(1'b1, DW'(4 + acceptedCount), 1'b1, 1'b1);
    checkOutput("early flush accepted", acceptedCount, 32'd5);
    applyStimulus(1'b1, 16'sd9, 1'b1, 1'b1);
    checkOutput("flush boundary in_ready", 32'(lastInReady), 32'd0);
    doFlush(1'b1, 16'sd9);
    checkOutput("no accept during flush", acceptedCount, 32'd5);
    for (int i = 1; i <= 4; i++) pushExp(DW'(i), 1'b0);
    for (int i = 5; i <= 8; i++) pushExp(DW'(i), i == 8);
    compareCapture("early flush");

    // Reset partway through frame 2 discards the tail
    doReset(2);
    for (int i = 0; i < 8; i++) addVec(DW'(i + 1), i < 4, DW'(i + 1));
    addVec(16'sd100, 1, 16'sd105); addVec(16'sd101, 1, 16'sd107);
    addVec(16'sd102, 1, 16'sd109); addVec(16'sd103, 1, 16'sd111);
    addVec(16'sd104, 0, '0);
    runVectors();
    compareCapture("pre-reset");
    doReset(1);
    for (int i = 0; i < 8; i++) addVec(DW'(i + 1), i < 4, DW'(i + 1));
    runVectors();
    for (int i = 5; i <= 8; i++) pushExp(DW'(i), i == 8);
    doFlush(1'b0, '0);
    compareCapture("post-reset");

    // HOP == FRAME_LEN: passthrough with one cycle of latency, empty flush
    passVals = '{16'sh0001, 16'sh7FFF, 16'sh8000, 16'sh1234, 16'shFFFF, 16'sh0000, 16'sh5555, 16'shAAAA};
    for (int i = 0; i < 8; i++) begin
      pValid  = 1'b1;
      pSample = passVals[i];
      #1;
      checkOutput("pass in_ready", 32'(pReady), 32'd1);
      @(negedge clk);
      checkOutput($sformatf("pass out[%0d]", i), 32'(pOut), 32'(passVals[i]));
      checkOutput("pass out_valid", 32'(pOutValid), 32'd1);
    end
    pValid = 1'b0;
    @(negedge clk);
    checkOutput("pass idle out_valid", 32'(pOutValid), 32'd0);
    pFlush = 1'b1;
    @(negedge clk);
    checkOutput("pass flush entry fd", 32'(pFd), 32'd0);
    checkOutput("pass flush entry out_valid", 32'(pOutValid), 32'd0);
    @(negedge clk);
    checkOutput("pass flush_done", 32'(pFd), 32'd1);
    checkOutput("pass flush out_valid", 32'(pOutValid), 32'd0);
    pFlush = 1'b0;
    @(negedge clk);
    checkOutput("pass flush_done pulse", 32'(pFd), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
